mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of all address ports.
REQ-002 Parameter DW, default 32: data width of all data ports.
REQ-003 Parameter MEM_LAT, default 2, legal range 1..7: cycles from mem_en to valid mem_rdata.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 if_req  in  1  fetch-stage read request; level, held until if_ack.
REQ-007 if_addr  in  AW  fetch byte address.
REQ-008 if_rdata  out  DW  fetched instruction word, registered.
REQ-009 if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-010 dm_req  in  1  memory-stage request; level, held until dm_ack.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  AW  load/store byte address.
REQ-013 dm_wdata  in  DW  store data.
REQ-014 dm_rdata  out  DW  load data, registered.
REQ-015 dm_ack  out  1  one-cycle pulse: load/store complete.
REQ-016 mem_en  out  1  one-cycle issue strobe to the shared single-port memory.
REQ-017 mem_we  out  1  write enable, valid with mem_en.
REQ-018 mem_addr  out  AW  registered address, valid with mem_en.
REQ-019 mem_wdata  out  DW  registered store data, valid with mem_en.
REQ-020 mem_rdata  in  DW  memory read data, valid exactly MEM_LAT cycles after mem_en.
REQ-021 stall_if  out  1  combinational if_req AND NOT if_ack.
REQ-022 stall_mem  out  1  combinational dm_req AND NOT dm_ack.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, ACK; exactly one transaction outstanding at any time.
REQ-024 IDLE: no request -> stay IDLE; any request -> select winner, latch winner address/we/wdata, go ISSUE.
REQ-025 Arbitration on conflict (both requests in IDLE): round-robin; winner is the requester not granted last; single requester always wins.
REQ-026 Last-granted pointer is updated only on a grant; its reset value makes dm the first winner on conflict.
REQ-027 ISSUE (one cycle): mem_en=1, mem_we=latched we (always 0 for fetch); load latency counter with MEM_LAT; go WAIT.
REQ-028 WAIT: decrement counter each cycle; in the cycle MEM_LAT cycles after ISSUE, capture mem_rdata into owner's rdata register (loads/fetches only); go ACK.
REQ-029 Exception for MEM_LAT=1: WAIT lasts one cycle.
REQ-030 ACK (one cycle): owner's ack=1; no arbitration in this state; go IDLE.
REQ-031 Total latency: grant decision in cycle T -> ack in cycle T+MEM_LAT+2; next grant decision no earlier than T+MEM_LAT+3.
REQ-032 Store: dm_rdata holds its previous value; dm_ack still pulses.
REQ-033 if_rdata and dm_rdata change only on capture and hold otherwise.
REQ-034 Request deasserted before grant: no transaction occurs.
REQ-035 Request deasserted or inputs changed after grant: ignored; transaction completes with latched values and ack.
REQ-036 mem_en, mem_we deasserted in all states except ISSUE; mem_addr/mem_wdata hold last values.

Reset
REQ-037 rst=0 at a rising edge: state IDLE, pointer to dm-first, counter 0, mem_en/mem_we/if_ack/dm_ack 0, mem_addr/mem_wdata/if_rdata/dm_rdata 0.
REQ-038 Reset mid-transaction abandons it: no ack is ever produced for it; late mem_rdata is ignored.

Verification (MEM_LAT=2)
REQ-039 if_req=1, if_addr=0x00000010 at T; memory returns 0x00500293 -> mem_en/mem_addr=0x10 at T+1, if_ack=1 with if_rdata=0x00500293 at T+4, stall_if=1 at T..T+3.
REQ-040 After reset, if_req and dm_req both rise at T -> dm_ack at T+4, if_ack at T+9; never both acks in one cycle.
REQ-041 Both requests held continuously for 4 transactions -> grant order dm, if, dm, if.
REQ-042 dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> one cycle mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; dm_ack at T+4; dm_rdata unchanged.
REQ-043 rst=0 in the cycle after ISSUE -> next cycle all outputs at reset values; no ack; next request starts a fresh T+4 transaction.
REQ-044 if_req pulsed for one cycle while dm is in WAIT -> no fetch transaction, if_ack never asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between a fetch port (if_*) and a data
//   port (dm_*). One transaction is outstanding at a time. When both ports
//   request in the same cycle, the port that was not granted last wins.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no transaction; arbitrate, latch the winner's request
//   ISSUE | mem_en strobe for one cycle, latency counter loaded
//   WAIT  | count down until mem_rdata is valid, then capture it
//   ACK   | one-cycle ack pulse to the owning port
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   if_req/if_addr                fetch request (level) and byte address
//   if_rdata/if_ack               registered fetch data, completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata data request (level), store flag, address, data
//   dm_rdata/dm_ack               registered load data, completion pulse
//   mem_en/mem_we                 issue strobe and write enable
//   mem_addr/mem_wdata            registered address and store data
//   mem_rdata                     read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem            request pending and not yet acked
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       owner_dm;   // 1: current transaction belongs to the data port
  logic       last_if;    // 1: fetch port was granted most recently
  logic       we_q;
  logic       grant;
  logic       grant_dm;
  logic       capture;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dm  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          grant     = 1'b1;
          // dm wins if it is the only requester, or on conflict when fetch went last
          grant_dm  = dm_req && (!if_req || last_if);
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // cnt==1 marks the cycle exactly MEM_LAT cycles after ISSUE
        if (cnt <= 3'd1) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign if_ack    = (state == ACK) && !owner_dm;
  assign dm_ack    = (state == ACK) && owner_dm;
  assign stall_if  = if_req && !if_ack;
  assign stall_mem = dm_req && !dm_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      owner_dm  <= 1'b0;
      last_if   <= 1'b1;   // makes dm the first winner on conflict
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nxt;

      if (grant) begin
        owner_dm <= grant_dm;
        last_if  <= !grant_dm;
        we_q     <= grant_dm && dm_we;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        if (grant_dm) mem_wdata <= dm_wdata;
      end

      if (state == ISSUE)
        cnt <= LAT_INIT;
      else if (state == WAIT && cnt != 3'd0)
        cnt <= cnt - 3'd1;

      if (capture && !we_q) begin
        if (owner_dm) dm_rdata <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2. A small memory model
// returns addr ^ K exactly two cycles after a read issue and junk otherwise.
module tb_mem_port_arbiter;

  localparam logic [31:0] K    = 32'h0050_0283;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // memory model: two-stage pipeline, data valid only in the MEM_LAT-th cycle
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_d = '0,   s2_d = '0;
  always @(posedge clk) begin
    s1_v <= mem_en && !mem_we;
    s1_d <= mem_addr ^ K;
    s2_v <= s1_v;
    s2_d <= s1_d;
  end
  assign mem_rdata = s2_v ? s2_d : JUNK;

  // monitors
  int          ack_total  = 0;
  int          both_acks  = 0;
  logic [31:0] grants[$];
  always @(posedge clk) begin
    if (if_ack || dm_ack) ack_total <= ack_total + 1;
    if (if_ack && dm_ack) both_acks <= both_acks + 1;
    if (mem_en) grants.push_back(mem_addr);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int base_acks;
  int base_grants;
  int seen;

  initial begin
    rst = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    tick(3);
    check("rst mem_en",    {31'd0, mem_en},    32'd0);
    check("rst mem_we",    {31'd0, mem_we},    32'd0);
    check("rst if_ack",    {31'd0, if_ack},    32'd0);
    check("rst dm_ack",    {31'd0, dm_ack},    32'd0);
    check("rst mem_addr",  mem_addr,           32'd0);
    check("rst mem_wdata", mem_wdata,          32'd0);
    check("rst if_rdata",  if_rdata,           32'd0);
    check("rst dm_rdata",  dm_rdata,           32'd0);
    rst = 1'b1;
    tick();

    // conflict right after reset: dm first, then if
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    #1;
    check("conf stall_if",  {31'd0, stall_if},  32'd1);
    check("conf stall_mem", {31'd0, stall_mem}, 32'd1);
    tick();
    check("conf mem_en dm",   {31'd0, mem_en}, 32'd1);
    check("conf mem_addr dm", mem_addr,        32'h40);
    tick(3);
    check("conf dm_ack",   {31'd0, dm_ack}, 32'd1);
    check("conf if_ack0",  {31'd0, if_ack}, 32'd0);
    check("conf dm_rdata", dm_rdata,        32'h0050_02C3);
    dm_req = 0;
    #1;
    check("conf stall_mem off", {31'd0, stall_mem}, 32'd0);
    tick(2);
    check("conf mem_en if",   {31'd0, mem_en}, 32'd1);
    check("conf mem_addr if", mem_addr,        32'h20);
    tick(2);
    check("conf if_ack early", {31'd0, if_ack}, 32'd0);
    check("conf stall_if T+8", {31'd0, stall_if}, 32'd1);
    tick();
    check("conf if_ack",   {31'd0, if_ack}, 32'd1);
    check("conf if_rdata", if_rdata,        32'h0050_02A3);
    if_req = 0;
    tick();

    // store: dm_rdata must keep the earlier load value
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("st mem_en",    {31'd0, mem_en}, 32'd1);
    check("st mem_we",    {31'd0, mem_we}, 32'd1);
    check("st mem_addr",  mem_addr,        32'h100);
    check("st mem_wdata", mem_wdata,       32'hDEAD_BEEF);
    tick();
    check("st mem_en off",  {31'd0, mem_en}, 32'd0);
    check("st mem_we off",  {31'd0, mem_we}, 32'd0);
    check("st wdata hold",  mem_wdata,       32'hDEAD_BEEF);
    tick(2);
    check("st dm_ack",   {31'd0, dm_ack}, 32'd1);
    check("st dm_rdata", dm_rdata,        32'h0050_02C3);
    dm_req = 0; dm_we = 0;
    tick();

    // single fetch; address change after grant is ignored
    if_req = 1; if_addr = 32'h10;
    #1;
    check("f stall_if T", {31'd0, stall_if}, 32'd1);
    tick();
    check("f mem_en",   {31'd0, mem_en}, 32'd1);
    check("f mem_we",   {31'd0, mem_we}, 32'd0);
    check("f mem_addr", mem_addr,        32'h10);
    if_addr = 32'h999;
    tick(3);
    check("f if_ack",   {31'd0, if_ack}, 32'd1);
    check("f if_rdata", if_rdata,        32'h0050_0293);
    check("f dm_rdata hold", dm_rdata,   32'h0050_02C3);
    if_req = 0;
    #1;
    check("f stall_if off", {31'd0, stall_if}, 32'd0);
    tick();
    check("f if_ack pulse", {31'd0, if_ack}, 32'd0);

    // round-robin from a fresh reset, both held for four transactions
    rst = 0;
    tick(2);
    rst = 1;
    tick();
    base_grants = grants.size();
    if_req = 1; if_addr = 32'h30; dm_req = 1; dm_we = 0; dm_addr = 32'h50;
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      tick();
      if (if_ack || dm_ack) seen++;
    end
    if_req = 0; dm_req = 0;
    check("rr acks", seen, 4);
    tick(4);
    check("rr grant count", grants.size() - base_grants, 4);
    if (grants.size() - base_grants >= 4) begin
      check("rr g0", grants[base_grants + 0], 32'h50);
      check("rr g1", grants[base_grants + 1], 32'h30);
      check("rr g2", grants[base_grants + 2], 32'h50);
      check("rr g3", grants[base_grants + 3], 32'h30);
    end

    // reset in the cycle after ISSUE abandons the transaction
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    tick(2);
    base_acks = ack_total;
    rst = 0; dm_req = 0;
    tick();
    rst = 1;
    check("mr mem_en",   {31'd0, mem_en}, 32'd0);
    check("mr mem_addr", mem_addr,        32'd0);
    check("mr dm_rdata", dm_rdata,        32'd0);
    check("mr if_rdata", if_rdata,        32'd0);
    tick(4);
    check("mr no ack", ack_total - base_acks, 0);
    check("mr dm_rdata late", dm_rdata, 32'd0);
    dm_req = 1; dm_addr = 32'h80;
    tick();
    check("mr new mem_addr", mem_addr, 32'h80);
    tick(3);
    check("mr new dm_ack",   {31'd0, dm_ack}, 32'd1);
    check("mr new dm_rdata", dm_rdata,        32'h0050_0203);
    dm_req = 0;
    tick();

    // fetch pulse during dm WAIT never becomes a transaction
    base_acks   = ack_total;
    base_grants = grants.size();
    dm_req = 1; dm_addr = 32'h70;
    tick(2);
    if_req = 1; if_addr = 32'h44;
    tick();
    if_req = 0;
    tick();
    check("pulse dm_ack", {31'd0, dm_ack}, 32'd1);
    dm_req = 0;
    tick(6);
    check("pulse grants", grants.size() - base_grants, 1);
    check("pulse acks",   ack_total - base_acks, 1);
    check("never both acks", both_acks, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
